// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, receiver state type and baud divider helper
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Clocks per oversample tick, truncated, never below one.
  function automatic int calc_div(input int sys_clk, input int baud);
    int d;
    d = sys_clk / (baud * OVERSAMPLE);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through synchronous FIFO for received bytes
module uart_rx_fifo #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [AWIDTH:0]   count,
  output logic              drop
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] FULL_CNT = DEPTH[AWIDTH:0];

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_path.sv
// rtl/uart_rx_path.sv - 8N1 UART receiver with 16x oversampling feeding a FWFT byte FIFO
module uart_rx_path
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FRP = 50_000_000,
  parameter int BAUDRATE    = 115200,
  parameter int FIFO_AWIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overflow,
  input  logic                 clear_ovf,
  output logic [FIFO_AWIDTH:0] fifo_count
);

  localparam int DIV = calc_div(SYS_CLK_FRP, BAUDRATE);
  localparam int TCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TCW-1:0] TICK_LAST = TCW'(DIV - 1);
  localparam logic [3:0] MID_LAST = 4'(MID_SAMPLE - 1);
  localparam logic [3:0] OS_LAST  = 4'(OVERSAMPLE - 1);

  logic           sync1;
  logic           rxs;
  logic [TCW-1:0] tick_cnt;
  logic           tick;
  rx_state_t      state;
  logic [3:0]     os_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           push;
  logic [7:0]     push_data;
  logic           fifo_empty;
  logic           fifo_full;
  logic           fifo_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rxs   <= sync1;
    end
  end

  // Held at zero while idle so the first tick lands a fixed distance from the start edge.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst || state == IDLE || tick) tick_cnt <= '0;
    else                              tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      push      <= 1'b0;
      push_data <= '0;
      frame_err <= 1'b0;
    end else begin
      push      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state  <= START;
            os_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (os_cnt == MID_LAST) begin
              os_cnt  <= '0;
              bit_idx <= '0;
              state   <= rxs ? IDLE : DATA;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt <= '0;
              shreg  <= {rxs, shreg[7:1]};
              if (bit_idx == 3'd7) state <= STOP;
              else                 bit_idx <= bit_idx + 3'd1;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt <= '0;
              if (rxs) begin
                push      <= 1'b1;
                push_data <= shreg;
                state     <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_HIGH;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .AWIDTH (FIFO_AWIDTH),
    .DWIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  assign rx_valid = !fifo_empty;

  // A drop in the same cycle as clear_ovf leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst)            overflow <= 1'b0;
    else if (fifo_drop) overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

endmodule

// File: doc/uart_rx_path.md
Name: uart_rx_path

Overview:
Receive-side companion to the team's UART transmit path. It takes the asynchronous serial line, recovers 8N1 frames with 16x oversampling, and buffers received bytes in a first-word-fall-through FIFO. The FIFO drains through a valid/ready interface. It sits between the board-level RX pin and the image-command parser.

Parameters:
SYS_CLK_FRP, 50_000_000, system clock frequency in Hz.
BAUDRATE, 115200, serial bit rate.
FIFO_AWIDTH, 4, FIFO address width; depth = 2**FIFO_AWIDTH.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
uart_rx  in  1  asynchronous serial input; idles high.
rx_data  out  8  head-of-FIFO byte; valid while rx_valid=1.
rx_valid  out  1  FIFO not empty.
rx_ready  in  1  consumer accepts; pop occurs when rx_valid && rx_ready.
frame_err  out  1  one-cycle pulse when a stop bit samples low.
overflow  out  1  sticky; set when a byte is dropped because the FIFO is full.
clear_ovf  in  1  clears overflow.
fifo_count  out  FIFO_AWIDTH+1  current occupancy.

Behaviour:
- Interface decided: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, overflow=0, fifo_count=0.
  - Synchronizer flops=1; FSM=IDLE; tick counter=0.
- uart_rx passes through a 2-flop synchronizer. All decisions use the synchronized value (rxs).
- Oversample tick: DIV = SYS_CLK_FRP/(BAUDRATE*16), integer-truncated, minimum 1.
  - Counter runs 0..DIV-1; tick asserts when the counter equals DIV-1.
  - In IDLE the counter is held at 0 and starts on start detection, so sampling is phase-aligned to the start edge.
- FSM:
  - IDLE: on rxs=0, go to START and clear the tick count.
  - START: after 8 ticks (mid start bit), sample. rxs=0 goes to DATA. rxs=1 is a glitch: go to IDLE, no other effect.
  - DATA: every 16 ticks, sample one bit, LSB first, into a shift register. After bit 7, go to STOP.
  - STOP: after 16 ticks, sample.
    - rxs=1: push the byte and go to IDLE.
    - rxs=0: pulse frame_err for 1 clk, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1 (break or stuck-low line), then go to IDLE. Prevents spurious frames during a break.
- Latency: the push strobe occurs in the clk after the mid-stop sample tick. rx_valid and rx_data are updated on the following edge, i.e. at most 2 clk after the stop-bit sample.
- FIFO (FWFT):
  - push && !full: write and increment the count.
  - push && full && !pop: drop the byte and set overflow.
  - push && pop when full: both happen; count unchanged; no overflow.
  - pop when empty: ignored.
  - Pointers wrap modulo depth; fifo_count spans 0..depth.
- overflow: clear_ovf clears it. If clear_ovf and a new drop occur in the same cycle, the set wins.
- Reset mid-frame: all state returns to reset values. The partial byte is lost; no frame_err is emitted.

Decomposition:
- Package uart_pkg holds:
  - OVERSAMPLE=16 and MID_SAMPLE=8.
  - The FSM state enum (IDLE, START, DATA, STOP, WAIT_HIGH).
  - A function computing DIV from SYS_CLK_FRP and BAUDRATE.
- One sub-module, uart_rx_fifo: a parameterized FWFT synchronous FIFO with push, pop, full, empty, count and the simultaneous push/pop rule above.
- Receiver FSM, synchronizer and tick generator live in uart_rx_path.

Test Plan:
All scenarios use SYS_CLK_FRP=16_000_000 and BAUDRATE=1_000_000, so DIV=1 and one bit = 16 clk.
1. Send 0xA5 framed 8N1, rx_ready=1 -> rx_valid high for exactly 1 clk with rx_data=0xA5, within 2 clk after the mid-stop sample; frame_err=0; fifo_count returns to 0.
2. Drive uart_rx low for 5 clk, then high -> START rejects the glitch; no push, fifo_count=0, FSM back in IDLE; a following 0x3C is received correctly.
3. Send 0x3C with stop bit 0, hold the line low 40 bit times, release, then send 0x55 -> one frame_err pulse, 0x3C not stored, no spurious frames during the low period, 0x55 received.
4. With rx_ready=0, send bytes 0x00..0x10 (17 bytes) -> fifo_count=16 and overflow=1 after the 17th. Draining yields 0x00..0x0F in order. A clear_ovf pulse clears overflow.
5. Fill the FIFO to 16, assert rx_ready=1 in the exact push cycle of byte 0x77 -> head popped, 0x77 stored, count stays 16, overflow stays 0, 0x77 is the last byte read.
6. Assert rst for 1 clk during data bit 4 of 0xFF -> no push, no frame_err, all outputs at reset values; the next frame 0x81 is received correctly.
